// File: rtl/hazard_if.sv
// Hazard-unit bundle: pipeline-side hazard inputs and the stall/flush/freeze
// controls and performance counters returned by the hazard unit.
interface hazard_if #(
  parameter int PERF_W = 16
);
  logic [4:0]        if_id_rs;
  logic [4:0]        if_id_rt;
  logic              uses_rt;
  logic [4:0]        id_ex_rt;
  logic              id_ex_mem_read;
  logic              branch_taken;
  logic              mem_req;
  logic              mem_ready;
  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              freeze;
  logic              mem_error;
  logic [PERF_W-1:0] stall_count;
  logic [PERF_W-1:0] flush_count;

  modport master (
    output if_id_rs, if_id_rt, uses_rt, id_ex_rt, id_ex_mem_read,
           branch_taken, mem_req, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, freeze,
           mem_error, stall_count, flush_count
  );

  modport slave (
    input  if_id_rs, if_id_rt, uses_rt, id_ex_rt, id_ex_mem_read,
           branch_taken, mem_req, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, freeze,
           mem_error, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_unit.sv
// ID-stage stall/flush controller: load-use bubbles, branch flushes and
// data-memory freeze, with saturating perf counters and a sticky timeout flag.
module hazard_unit #(
  parameter int PERF_W      = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave hz
);

  typedef enum logic [1:0] {RUN, LOADSTALL, MEMWAIT} state_e;

  localparam logic [9:0] TIMEOUT = 10'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [9:0]        wait_cnt_q, wait_cnt_d;
  logic              mem_error_q;
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

  logic mem_wait, load_use, stall_evt, flush_evt;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush, freeze;

  assign mem_wait = hz.mem_req & ~hz.mem_ready;
  assign load_use = hz.id_ex_mem_read & (hz.id_ex_rt != 5'd0) &
                    ((hz.id_ex_rt == hz.if_id_rs) |
                     (hz.uses_rt & (hz.id_ex_rt == hz.if_id_rt)));

  // Leaving MEMWAIT on memReady is a plain RUN evaluation, so MEMWAIT and
  // RUN share the same decode; only LOADSTALL masks load-use detection.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    freeze      = 1'b0;
    stall_evt   = 1'b0;
    flush_evt   = 1'b0;
    state_d     = RUN;
    if (mem_wait) begin
      freeze      = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      stall_evt   = 1'b1;
      state_d     = MEMWAIT;
    end else if (hz.branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      flush_evt   = 1'b1;
    end else if (load_use && state_q != LOADSTALL) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      stall_evt   = 1'b1;
      state_d     = LOADSTALL;
    end
    if (rst) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      freeze      = 1'b0;
      stall_evt   = 1'b0;
      flush_evt   = 1'b0;
      state_d     = RUN;
    end
  end

  // Counts consecutive wait cycles, holding at the timeout value.
  always_comb begin
    wait_cnt_d = '0;
    if (mem_wait) wait_cnt_d = (wait_cnt_q == TIMEOUT) ? wait_cnt_q : wait_cnt_q + 10'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (mem_wait && wait_cnt_d == TIMEOUT) mem_error_q <= 1'b1;
      if (stall_evt && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_evt && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign hz.pc_write    = pc_write;
  assign hz.if_id_write = if_id_write;
  assign hz.if_id_flush = if_id_flush;
  assign hz.id_ex_flush = id_ex_flush;
  assign hz.freeze      = freeze;
  assign hz.mem_error   = mem_error_q;
  assign hz.stall_count = stall_cnt_q;
  assign hz.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench: two hazard_unit configurations share one stimulus
// stream and are compared every cycle against a rule-level reference model.
module tb_hazard_unit;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses;
    logic [4:0] ex_rt;
    logic       rd;
    logic       br;
    logic       req;
    logic       rdy;
  } vec_t;

  typedef struct {
    int stall;
    int flush;
    int run;
    bit err;
    bit bubble;
  } model_t;

  localparam vec_t IDLE = '0;

  logic clk = 1'b0;
  vec_t v   = IDLE;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  model_t m [2];
  int     perf_max [2] = '{65535, 3};
  int     timeout  [2] = '{4, 6};

  always #5 clk = ~clk;
  assign rst = v.rst;

  hazard_if #(.PERF_W(16)) bus0 ();
  hazard_if #(.PERF_W(2))  bus1 ();

  assign bus0.if_id_rs = v.rs;         assign bus1.if_id_rs = v.rs;
  assign bus0.if_id_rt = v.rt;         assign bus1.if_id_rt = v.rt;
  assign bus0.uses_rt = v.uses;        assign bus1.uses_rt = v.uses;
  assign bus0.id_ex_rt = v.ex_rt;      assign bus1.id_ex_rt = v.ex_rt;
  assign bus0.id_ex_mem_read = v.rd;   assign bus1.id_ex_mem_read = v.rd;
  assign bus0.branch_taken = v.br;     assign bus1.branch_taken = v.br;
  assign bus0.mem_req = v.req;         assign bus1.mem_req = v.req;
  assign bus0.mem_ready = v.rdy;       assign bus1.mem_ready = v.rdy;

  hazard_unit #(.PERF_W(16), .MEM_TIMEOUT(4)) u_dut0 (.clk(clk), .rst(rst), .hz(bus0));
  hazard_unit #(.PERF_W(2),  .MEM_TIMEOUT(6)) u_dut1 (.clk(clk), .rst(rst), .hz(bus1));

  // {pcWrite, IfIdWrite, IfIdFlush, IdExFlush, freeze, memError}
  logic [5:0]  obs_ctl   [2];
  logic [15:0] obs_stall [2];
  logic [15:0] obs_flush [2];

  assign obs_ctl[0] = {bus0.pc_write, bus0.if_id_write, bus0.if_id_flush,
                       bus0.id_ex_flush, bus0.freeze, bus0.mem_error};
  assign obs_ctl[1] = {bus1.pc_write, bus1.if_id_write, bus1.if_id_flush,
                       bus1.id_ex_flush, bus1.freeze, bus1.mem_error};
  assign obs_stall[0] = bus0.stall_count;
  assign obs_flush[0] = bus0.flush_count;
  assign obs_stall[1] = {14'd0, bus1.stall_count};
  assign obs_flush[1] = {14'd0, bus1.flush_count};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int val, input int max);
    return (val >= max) ? max : val + 1;
  endfunction

  // Drive one cycle of stimulus, compare both DUTs against the model, then
  // advance the model to what the coming rising edge should produce.
  task automatic step(input vec_t nv);
    bit         mw, lu;
    logic [5:0] e;
    @(negedge clk);
    v = nv;
    #1;
    mw = v.req && !v.rdy;
    lu = v.rd && v.ex_rt != 0 && (v.ex_rt == v.rs || (v.uses && v.ex_rt == v.rt));
    for (int k = 0; k < 2; k++) begin
      if (v.rst) begin
        m[k].stall = 0; m[k].flush = 0; m[k].run = 0;
        m[k].err = 1'b0; m[k].bubble = 1'b0;
      end
      if (v.rst)                     e = 6'b000000;
      else if (mw)                   e = 6'b000010;
      else if (v.br)                 e = 6'b111100;
      else if (lu && !m[k].bubble)   e = 6'b000100;
      else                           e = 6'b110000;
      e[0] = m[k].err;
      check($sformatf("ctl%0d", k), 32'(obs_ctl[k]), 32'(e));
      check($sformatf("stall%0d", k), 32'(obs_stall[k]), 32'(m[k].stall));
      check($sformatf("flush%0d", k), 32'(obs_flush[k]), 32'(m[k].flush));
      if (!v.rst) begin
        if (mw) begin
          m[k].stall  = sat_inc(m[k].stall, perf_max[k]);
          m[k].run    = m[k].run + 1;
          if (m[k].run >= timeout[k]) m[k].err = 1'b1;
          m[k].bubble = 1'b0;
        end else begin
          m[k].run = 0;
          if (v.br) begin
            m[k].flush  = sat_inc(m[k].flush, perf_max[k]);
            m[k].bubble = 1'b0;
          end else if (lu && !m[k].bubble) begin
            m[k].stall  = sat_inc(m[k].stall, perf_max[k]);
            m[k].bubble = 1'b1;
          end else begin
            m[k].bubble = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    vec_t t;
    t = IDLE;
    t.rst = 1'b1;
    step(t);
    step(IDLE);
  endtask

  initial begin
    vec_t t;
    bit   hold_req;
    for (int k = 0; k < 2; k++) begin
      m[k].stall = 0; m[k].flush = 0; m[k].run = 0; m[k].err = 1'b0; m[k].bubble = 1'b0;
    end

    t = IDLE; t.rst = 1'b1;
    step(t);
    check("rst_pc", 32'(bus0.pc_write), 32'd0);
    check("rst_freeze", 32'(bus0.freeze), 32'd0);
    step(IDLE);
    check("run_pc", 32'(bus0.pc_write), 32'd1);

    // lw $5 then dependent add: one bubble, then masked.
    t = IDLE; t.rd = 1'b1; t.ex_rt = 5'd5; t.rs = 5'd5;
    step(t);
    check("lu_pc", 32'(bus0.pc_write), 32'd0);
    check("lu_idflush", 32'(bus0.id_ex_flush), 32'd1);
    step(t);
    check("lu_masked_pc", 32'(bus0.pc_write), 32'd1);
    step(IDLE);
    check("lu_stall_cnt", 32'(bus0.stall_count), 32'd1);

    // Register $0 and an unused rt never stall.
    t = IDLE; t.rd = 1'b1;
    step(t);
    check("r0_pc", 32'(bus0.pc_write), 32'd1);
    t.ex_rt = 5'd7; t.rt = 5'd7; t.rs = 5'd1; t.uses = 1'b0;
    step(t);
    check("nouse_pc", 32'(bus0.pc_write), 32'd1);

    // Branch with a simultaneous load-use: flush only.
    do_reset();
    t = IDLE; t.rd = 1'b1; t.ex_rt = 5'd5; t.rs = 5'd5; t.br = 1'b1;
    step(t);
    check("br_flushes", 32'({bus0.if_id_flush, bus0.id_ex_flush, bus0.pc_write}), 32'b111);
    step(IDLE);
    check("br_flush_cnt", 32'(bus0.flush_count), 32'd1);
    check("br_stall_cnt", 32'(bus0.stall_count), 32'd0);

    // Three-cycle memory wait.
    do_reset();
    t = IDLE; t.req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(t);
      check("mw_freeze", 32'({bus0.freeze, bus0.pc_write}), 32'b10);
    end
    t.rdy = 1'b1;
    step(t);
    check("mw_release", 32'({bus0.freeze, bus0.pc_write}), 32'b01);
    step(IDLE);
    check("mw_stall_cnt", 32'(bus0.stall_count), 32'd3);

    // Timeout of 4 on DUT 0 with a six-cycle wait.
    do_reset();
    t = IDLE; t.req = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(t);
      check("to_err", 32'(bus0.mem_error), 32'(i >= 5));
    end
    t.rdy = 1'b1;
    step(t);
    step(IDLE);
    check("to_sticky", 32'(bus0.mem_error), 32'd1);
    t = IDLE; t.rst = 1'b1;
    step(t);
    check("to_rst", 32'(bus0.mem_error), 32'd0);

    // PERF_W=2 saturation and reset during a wait on DUT 1.
    do_reset();
    t = IDLE; t.br = 1'b1;
    for (int i = 0; i < 5; i++) step(t);
    step(IDLE);
    check("sat_flush", 32'(bus1.flush_count), 32'd3);
    t = IDLE; t.req = 1'b1;
    step(t);
    step(t);
    t.rst = 1'b1;
    step(t);
    check("rst_mw", 32'({bus1.freeze, bus1.stall_count, bus1.flush_count}), 32'd0);
    step(IDLE);

    // Randomized traffic; requests tend to persist so long waits occur.
    hold_req = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      t.rst   = ($urandom_range(0, 149) == 0);
      t.rs    = 5'($urandom_range(0, 3));
      t.rt    = 5'($urandom_range(0, 3));
      t.uses  = 1'($urandom_range(0, 1));
      t.ex_rt = 5'($urandom_range(0, 3));
      t.rd    = 1'($urandom_range(0, 1));
      t.br    = ($urandom_range(0, 5) == 0);
      t.req   = hold_req ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
      t.rdy   = ($urandom_range(0, 3) == 0);
      hold_req = t.req && !t.rdy;
      step(t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- ID-stage stall/flush controller for the 5-stage MIPS pipeline.
- Works as the counterpart to the EX-stage operand forwarding: it handles the cases forwarding cannot resolve.
  - Load-use hazards: inserts a one-cycle bubble.
  - Taken branches/jumps resolved in EX: flushes IF/ID and ID/EX.
  - Data-memory wait handshake: freezes the whole pipeline.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
- PERF_W, 16, width of stallCount and flushCount.
- MEM_TIMEOUT, 255, max consecutive memory-wait cycles before memError sets (1..2^10-1).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- IfIdRs  in  5  rs field of instruction in ID.
- IfIdRt  in  5  rt field of instruction in ID.
- usesRt  in  1  ID instruction reads rt as a source.
- IdExRt  in  5  rt (load destination) of instruction in EX.
- IdExMemRead  in  1  instruction in EX is a load.
- branchTaken  in  1  EX resolved a taken branch/jump this cycle.
- memReq  in  1  MEM stage is accessing data memory.
- memReady  in  1  data memory completes the access this cycle.
- pcWrite  out  1  PC register load enable.
- IfIdWrite  out  1  IF/ID register load enable.
- IfIdFlush  out  1  clear IF/ID to NOP.
- IdExFlush  out  1  clear ID/EX control to bubble.
- freeze  out  1  hold ID/EX, EX/MEM and MEM/WB registers.
- memError  out  1  sticky: memory wait exceeded MEM_TIMEOUT.
- stallCount  out  PERF_W  stall cycles, saturating.
- flushCount  out  PERF_W  branch flush events, saturating.

Behaviour:
- FSM states: RUN, LOADSTALL, MEMWAIT. The state register and counters are reset asynchronously.
- While rst=1:
  - state=RUN; pcWrite=0, IfIdWrite=0, IfIdFlush=0, IdExFlush=0, freeze=0.
  - memError=0, stallCount=0, flushCount=0, internal waitCnt=0.
- Outputs are combinational from state and current inputs (same-cycle response). The state, counters and memError update on the rising clk edge.
- Defaults (RUN, no event): pcWrite=1, IfIdWrite=1, flushes=0, freeze=0.
- Definitions:
  - memWait = memReq & ~memReady.
  - loadUse = IdExMemRead & (IdExRt!=0) & ((IdExRt==IfIdRs) | (usesRt & IdExRt==IfIdRt)).
- Priority is memWait > branchTaken > loadUse, evaluated in RUN and LOADSTALL.
- memWait:
  - Outputs: freeze=1, pcWrite=0, IfIdWrite=0, no flushes.
  - Next state is MEMWAIT.
  - branchTaken and loadUse are ignored; EX is frozen, so they re-present after the wait.
- MEMWAIT state:
  - Same outputs as memWait while memReady=0.
  - waitCnt increments each cycle. When waitCnt reaches MEM_TIMEOUT, memError sets and stays set until reset; the wait itself continues.
  - On memReady=1, outputs revert to normal RUN evaluation in that same cycle, waitCnt clears, and next state is RUN.
  - waitCnt also clears whenever the FSM is not in MEMWAIT.
- branchTaken (no memWait):
  - Outputs: IfIdFlush=1, IdExFlush=1, pcWrite=1, IfIdWrite=1.
  - loadUse is suppressed because the ID instruction is squashed. Next state is RUN.
  - flushCount increments by 1.
- loadUse (no memWait, no branch, state RUN):
  - Outputs: pcWrite=0, IfIdWrite=0, IdExFlush=1.
  - Next state is LOADSTALL.
- LOADSTALL state:
  - loadUse detection is masked: exactly one bubble per load.
  - Otherwise RUN rules apply. Next state is RUN unless memWait, which goes to MEMWAIT.
- stallCount increments by 1 for each cycle with a load-use stall or freeze=1.
- Both counters saturate at 2^PERF_W-1 with no wrap.
- A branch and a load-use in the same cycle produce a flush only; stallCount does not increment.
- Register $0 never causes a stall.
- rst asserted mid-MEMWAIT or mid-LOADSTALL aborts immediately to the reset values above.

Test Plan:
- lw $5 in EX (IdExMemRead=1, IdExRt=5), ID add with IfIdRs=5 -> cycle N: pcWrite=0, IfIdWrite=0, IdExFlush=1; cycle N+1 with inputs held: pcWrite=1 (masked); stallCount=1.
- IdExRt=0 with IdExMemRead=1, IfIdRs=0 -> no stall; IdExRt=7, IfIdRt=7, usesRt=0 -> no stall.
- branchTaken=1 together with a load-use match -> IfIdFlush=IdExFlush=1, pcWrite=1, flushCount=1, stallCount=0.
- memReq=1, memReady=0 for 3 cycles then memReady=1 -> freeze=1 and pcWrite=0 for 3 cycles, normal outputs on the 4th; stallCount=3.
- MEM_TIMEOUT=4, memReady held 0 for 6 cycles -> memError rises after the 4th wait cycle and stays 1 after memReady; rst then clears it.
- PERF_W=2, 5 branch flushes -> flushCount stops at 3; asserting rst mid-MEMWAIT -> freeze=0 immediately, counters 0.
